mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port, round-robin arbiter and sequencer for the single shared instruction/data memory of the multicycle CPU. The block serialises accesses from the CPU memory port and from a secondary bus master (debug loader or display reader) onto one synchronous memory with a fixed read latency. It returns one `ready` pulse per completed transaction, and the CPU uses this pulse as its `MIO_ready` input.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 2: cycles from the `mem_en` cycle to the cycle in which `mem_rdata` is valid; legal values are 1 to 15.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `cpu_req`, input, 1: CPU request; held high until `cpu_ready`.
- `cpu_we`, input, 1: CPU write enable; 1 means write.
- `cpu_addr`, input, `ADDR_W`: CPU address.
- `cpu_wdata`, input, `DATA_W`: CPU write data.
- `cpu_rdata`, output, `DATA_W`: CPU read data.
- `cpu_ready`, output, 1: one-cycle completion pulse to the CPU (`MIO_ready`).
- `dev_req`, `dev_we`, `dev_addr`, `dev_wdata`, input, 1/1/`ADDR_W`/`DATA_W`: secondary master request, with the same rules as the CPU port.
- `dev_rdata`, output, `DATA_W`: secondary master read data.
- `dev_ready`, output, 1: secondary master completion pulse.
- `mem_en`, output, 1: memory access strobe, high for one cycle per transaction.
- `mem_we`, output, 1: memory write enable; qualified by `mem_en`.
- `mem_addr`, output, `ADDR_W`: memory address.
- `mem_wdata`, output, `DATA_W`: memory write data.
- `mem_rdata`, input, `DATA_W`: memory read data.
- `grant`, output, 2: current owner; 01 = CPU, 10 = device, 00 = none.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, DONE.
- **IDLE:**
  - Samples `cpu_req` and `dev_req`.
  - If at least one is high, latches the winner's `we`, `addr` and `wdata`, sets `grant`, and moves to ACCESS.
  - Otherwise stays in IDLE.
- **Arbitration:**
  - A single requester always wins.
  - When both request, the port not granted last time wins.
  - The `last` register resets to "device", so the CPU wins the first tie after reset.
  - `last` updates when a grant is made in IDLE.
- **ACCESS:**
  - `mem_en` = 1, `mem_we` = latched `we`; `mem_addr` and `mem_wdata` carry the latched values.
  - Loads the wait counter with `MEM_LAT` and moves to WAIT.
- **WAIT:**
  - Counter decrements each cycle.
  - When the counter reaches 1, the block captures `mem_rdata` into the granted port's rdata register (reads only) and moves to DONE.
- **DONE:**
  - Asserts the granted port's `ready` for exactly one cycle.
  - Clears `grant` and returns to IDLE.
- **Request rules:**
  - Each requester holds `req` and its fields stable from assertion until its `ready` pulse.
  - Request fields are sampled only in the IDLE cycle in which the grant is made.
  - A `req` still high in the cycle after `ready` (the IDLE cycle) is a new request.
  - Requests arriving during ACCESS, WAIT or DONE wait until IDLE.
- **rdata outputs:**
  - `cpu_rdata` and `dev_rdata` hold their last captured value until the next completed read on that port.
  - Writes leave rdata unchanged.
- **Memory outputs:**
  - `mem_addr`, `mem_wdata` and `mem_we` hold the latched values outside ACCESS.
  - The memory may only treat them as meaningful while `mem_en` = 1.
- **Reset (any state, including mid-transaction):**
  - The FSM goes to IDLE.
  - All outputs go to 0: `grant`, `ready`s, `mem_*`, both rdata registers.
  - `last` goes to "device".
  - A pending transaction is dropped without a `ready`.
  - A write already strobed is not retracted.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- **Latency:**
  - `req` is sampled high in IDLE at cycle N.
  - `mem_en` is high in cycle N+1.
  - `mem_rdata` is sampled in cycle N+1+`MEM_LAT`.
  - `ready` is high in cycle N+2+`MEM_LAT`.
  - Reads and writes have the same latency.
- **Throughput:** one transaction per `MEM_LAT`+3 cycles under continuous demand.
- **Contention:** under continuous contention, grants strictly alternate CPU, device, CPU, ... with no starvation.
- **Exclusivity:** at most one `ready` is high in any cycle, and `grant` is one-hot or zero.

## Test plan
- **CPU read, `MEM_LAT` = 2:**
  - Stimulus: `cpu_req` = 1, `addr` = 0x10 at cycle 0; the memory model returns 0xDEADBEEF.
  - Required: `mem_en` = 1 with `mem_addr` = 0x10 in cycle 1; `cpu_ready` pulse in cycle 4 with `cpu_rdata` = 0xDEADBEEF; `grant` = 00 in cycle 5.
- **Device write:**
  - Stimulus: `dev_req` = 1, `we` = 1, `addr` = 0x200, `wdata` = 0x12345678.
  - Required: exactly one `mem_en` cycle with `mem_we` = 1 and matching `addr`/`wdata`; `dev_ready` at N+4; `dev_rdata` unchanged.
- **First tie after reset:**
  - Stimulus: `cpu_req` and `dev_req` both rise in the same cycle after reset.
  - Required: CPU is served first, then the device; the `ready` pulses are 5 cycles apart, and `grant` is never 11.
- **Sustained contention:**
  - Stimulus: both ports hold `req` high continuously for 6 transactions.
  - Required: `grant` order is CPU, dev, CPU, dev, CPU, dev; each port receives 3 `ready` pulses.
- **Reset mid-transaction:**
  - Stimulus: assert `reset` during WAIT of a CPU read.
  - Required: all outputs are 0 immediately (asynchronously); no `cpu_ready` is issued; after release, a held `cpu_req` restarts from IDLE with full latency.
- **`MEM_LAT` = 1 corner:**
  - Stimulus: back-to-back CPU reads at addresses 0x0 and 0x4 with `req` held high.
  - Required: `ready` pulses in cycles 3 and 7; the rdata values match in order.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin two-port arbiter/sequencer for one fixed-latency memory.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] c_mem_lat = 4'(MEM_LAT);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last_dev;
  logic       r_sel_dev;
  logic       w_pick_dev;

  // On a tie the device wins only if the CPU was the previous owner.
  assign w_pick_dev = dev_req & (~cpu_req | ~r_last_dev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_last_dev <= 1'b1;
      r_sel_dev  <= 1'b0;
      grant      <= 2'b00;
      cpu_ready  <= 1'b0;
      dev_ready  <= 1'b0;
      cpu_rdata  <= '0;
      dev_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dev_ready <= 1'b0;
      mem_en    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req || dev_req) begin
            r_sel_dev  <= w_pick_dev;
            r_last_dev <= w_pick_dev;
            grant      <= w_pick_dev ? 2'b10 : 2'b01;
            mem_we     <= w_pick_dev ? dev_we    : cpu_we;
            mem_addr   <= w_pick_dev ? dev_addr  : cpu_addr;
            mem_wdata  <= w_pick_dev ? dev_wdata : cpu_wdata;
            mem_en     <= 1'b1;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt   <= c_mem_lat;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            if (!mem_we) begin
              if (r_sel_dev) dev_rdata <= mem_rdata;
              else           cpu_rdata <= mem_rdata;
            end
            cpu_ready <= ~r_sel_dev;
            dev_ready <= r_sel_dev;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          grant   <= 2'b00;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Bench for mem_arbiter: directed scenarios plus random two-master traffic
// checked against a transaction-level scheduling model.
module tb_mem_arbiter;
  localparam int LAT  = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset1;
  logic        cpu_req, cpu_we, dev_req, dev_we;
  logic [31:0] cpu_addr, cpu_wdata, dev_addr, dev_wdata;
  logic [31:0] cpu_rdata, dev_rdata;
  logic        cpu_ready, dev_ready;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  grant;

  logic        l1_cpu_req, l1_cpu_we, l1_dev_req, l1_dev_we;
  logic [31:0] l1_cpu_addr, l1_cpu_wdata, l1_dev_addr, l1_dev_wdata;
  logic [31:0] l1_cpu_rdata, l1_dev_rdata;
  logic        l1_cpu_ready, l1_dev_ready;
  logic        l1_mem_en, l1_mem_we;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_rd;
  logic [1:0]  l1_grant;

  int vectors     = 0;
  int miscompares = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ready(dev_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1)) dut_l1 (
    .clk(clk), .reset(reset1),
    .cpu_req(l1_cpu_req), .cpu_we(l1_cpu_we), .cpu_addr(l1_cpu_addr), .cpu_wdata(l1_cpu_wdata),
    .cpu_rdata(l1_cpu_rdata), .cpu_ready(l1_cpu_ready),
    .dev_req(l1_dev_req), .dev_we(l1_dev_we), .dev_addr(l1_dev_addr), .dev_wdata(l1_dev_wdata),
    .dev_rdata(l1_dev_rdata), .dev_ready(l1_dev_ready),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_rd), .grant(l1_grant)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h5A000000 ^ (32'(i) * 32'h00010203);
  endfunction

  // Memory with a MEM_LAT-deep read pipeline; unused slots carry junk.
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rd_pipe [0:LAT-1];
  logic        mem_inited = 1'b0;

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[11:2]] : 32'hBAD0BAD0;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk)
    l1_rd <= (l1_mem_en && !l1_mem_we) ? mem[l1_mem_addr[11:2]] : 32'hBAD1BAD1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev_req = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    l1_cpu_req = 1'b0; l1_cpu_we = 1'b0; l1_cpu_addr = '0; l1_cpu_wdata = '0;
    l1_dev_req = 1'b0; l1_dev_we = 1'b0; l1_dev_addr = '0; l1_dev_wdata = '0;
    reset = 1'b1; reset1 = 1'b1;
    repeat (3) step();
    vectors++;
    if ({grant, cpu_ready, dev_ready, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dev_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got grant=%b rdy=%b%b en=%b we=%b addr=%h wd=%h crd=%h drd=%h, expected all 0",
               grant, cpu_ready, dev_ready, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dev_rdata);
    end
    vectors++;
    if ({l1_grant, l1_cpu_ready, l1_dev_ready, l1_mem_en, l1_mem_we, l1_mem_addr, l1_cpu_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_l1: got grant=%b rdy=%b en=%b addr=%h crd=%h, expected all 0",
               l1_grant, l1_cpu_ready, l1_mem_en, l1_mem_addr, l1_cpu_rdata);
    end
    reset = 1'b0; reset1 = 1'b0;
    step();
  endtask

  task automatic test_cpu_read();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    for (int c = 1; c <= 5; c++) begin
      step();
      vectors++;
      if (mem_en !== (c == 1)) begin
        miscompares++; $display("FAIL cpu_read_mem_en c=%0d: got %b expected %b", c, mem_en, (c == 1));
      end
      if (c == 1) begin
        vectors++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
          miscompares++; $display("FAIL cpu_read_mem_addr: got %h we=%b expected 00000010 we=0", mem_addr, mem_we);
        end
      end
      vectors++;
      if (cpu_ready !== (c == 4) || dev_ready !== 1'b0) begin
        miscompares++; $display("FAIL cpu_read_ready c=%0d: got %b%b expected %b0", c, cpu_ready, dev_ready, (c == 4));
      end
      vectors++;
      if (grant !== ((c <= 4) ? 2'b01 : 2'b00)) begin
        miscompares++; $display("FAIL cpu_read_grant c=%0d: got %b expected %b", c, grant, (c <= 4) ? 2'b01 : 2'b00);
      end
      if (c == 4) begin
        vectors++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
          miscompares++; $display("FAIL cpu_read_rdata: got %h expected deadbeef", cpu_rdata);
        end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_dev_write();
    step();
    dev_req = 1'b1; dev_we = 1'b1; dev_addr = 32'h200; dev_wdata = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      step();
      vectors++;
      if (mem_en !== (c == 1)) begin
        miscompares++; $display("FAIL dev_write_mem_en c=%0d: got %b expected %b", c, mem_en, (c == 1));
      end
      if (c == 1) begin
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'h12345678}) begin
          miscompares++; $display("FAIL dev_write_fields: got we=%b addr=%h wd=%h expected 1 00000200 12345678",
                                  mem_we, mem_addr, mem_wdata);
        end
      end
      vectors++;
      if (dev_ready !== (c == 4) || cpu_ready !== 1'b0) begin
        miscompares++; $display("FAIL dev_write_ready c=%0d: got cpu=%b dev=%b expected 0 %b", c, cpu_ready, dev_ready, (c == 4));
      end
      vectors++;
      if (dev_rdata !== 32'h0) begin
        miscompares++; $display("FAIL dev_write_rdata c=%0d: got %h expected 00000000", c, dev_rdata);
      end
      if (c == 4) dev_req = 1'b0;
    end
    ref_mem[128] = 32'h12345678;
  endtask

  task automatic test_first_tie();
    int cpu_rc, dev_rc;
    cpu_rc = -1; dev_rc = -1;
    pulse_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      step();
      vectors++;
      if (grant === 2'b11) begin
        miscompares++; $display("FAIL tie_grant_onehot c=%0d: got %b expected not 11", c, grant);
      end
      if (c == 1 || c == 6) begin
        vectors++;
        if (grant !== ((c == 1) ? 2'b01 : 2'b10)) begin
          miscompares++; $display("FAIL tie_owner c=%0d: got %b expected %b", c, grant, (c == 1) ? 2'b01 : 2'b10);
        end
      end
      if (cpu_ready === 1'b1) begin cpu_rc = c; cpu_req = 1'b0; end
      if (dev_ready === 1'b1) begin dev_rc = c; dev_req = 1'b0; end
    end
    vectors++;
    if (cpu_rc != 4 || dev_rc != 9) begin
      miscompares++; $display("FAIL tie_ready_cycles: got cpu=%0d dev=%0d expected cpu=4 dev=9", cpu_rc, dev_rc);
    end
    vectors++;
    if (cpu_rdata !== ref_mem[8] || dev_rdata !== ref_mem[16]) begin
      miscompares++; $display("FAIL tie_rdata: got %h/%h expected %h/%h", cpu_rdata, dev_rdata, ref_mem[8], ref_mem[16]);
    end
  endtask

  task automatic test_contention();
    int n_grant, n_cpu, n_dev, last_rc;
    logic [1:0] exp_g;
    n_grant = 0; n_cpu = 0; n_dev = 0; last_rc = -1;
    pulse_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h24;
    dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h44;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (mem_en === 1'b1) begin
        exp_g = (n_grant % 2 == 0) ? 2'b01 : 2'b10;
        vectors++;
        if (grant !== exp_g) begin
          miscompares++; $display("FAIL contention_order #%0d: got %b expected %b", n_grant, grant, exp_g);
        end
        n_grant++;
      end
      vectors++;
      if (cpu_ready === 1'b1 && dev_ready === 1'b1) begin
        miscompares++; $display("FAIL contention_exclusive c=%0d: got both ready expected at most one", c);
      end
      if (cpu_ready === 1'b1 || dev_ready === 1'b1) begin
        if (last_rc >= 0) begin
          vectors++;
          if (c - last_rc != LAT + 3) begin
            miscompares++; $display("FAIL contention_spacing c=%0d: got %0d expected %0d", c, c - last_rc, LAT + 3);
          end
        end
        last_rc = c;
      end
      if (cpu_ready === 1'b1) begin n_cpu++; if (n_cpu == 3) cpu_req = 1'b0; end
      if (dev_ready === 1'b1) begin n_dev++; if (n_dev == 3) dev_req = 1'b0; end
    end
    vectors++;
    if (n_grant != 6 || n_cpu != 3 || n_dev != 3) begin
      miscompares++; $display("FAIL contention_counts: got grants=%0d cpu=%0d dev=%0d expected 6 3 3", n_grant, n_cpu, n_dev);
    end
  endtask

  task automatic test_reset_mid();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({grant, cpu_ready, dev_ready, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dev_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got grant=%b rdy=%b%b en=%b addr=%h crd=%h drd=%h expected all 0",
               grant, cpu_ready, dev_ready, mem_en, mem_addr, cpu_rdata, dev_rdata);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (cpu_ready !== 1'b0 || grant !== 2'b00) begin
        miscompares++; $display("FAIL reset_mid_held k=%0d: got rdy=%b grant=%b expected 0 00", k, cpu_ready, grant);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      vectors++;
      if (mem_en !== (c == 1) || cpu_ready !== (c == 4)) begin
        miscompares++; $display("FAIL reset_mid_restart c=%0d: got en=%b rdy=%b expected %b %b",
                                c, mem_en, cpu_ready, (c == 1), (c == 4));
      end
      if (c == 4) begin
        vectors++;
        if (cpu_rdata !== ref_mem[12]) begin
          miscompares++; $display("FAIL reset_mid_rdata: got %h expected %h", cpu_rdata, ref_mem[12]);
        end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_lat1();
    l1_cpu_req = 1'b1; l1_cpu_we = 1'b0; l1_cpu_addr = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      step();
      vectors++;
      if (l1_mem_en !== (c == 1 || c == 5)) begin
        miscompares++; $display("FAIL lat1_mem_en c=%0d: got %b expected %b", c, l1_mem_en, (c == 1 || c == 5));
      end
      if (c == 1 || c == 5) begin
        vectors++;
        if (l1_mem_addr !== ((c == 1) ? 32'h0 : 32'h4)) begin
          miscompares++; $display("FAIL lat1_addr c=%0d: got %h expected %h", c, l1_mem_addr, (c == 1) ? 32'h0 : 32'h4);
        end
      end
      vectors++;
      if (l1_cpu_ready !== (c == 3 || c == 7)) begin
        miscompares++; $display("FAIL lat1_ready c=%0d: got %b expected %b", c, l1_cpu_ready, (c == 3 || c == 7));
      end
      if (c == 3 || c == 7) begin
        vectors++;
        if (l1_cpu_rdata !== ref_mem[(c == 3) ? 0 : 1]) begin
          miscompares++; $display("FAIL lat1_rdata c=%0d: got %h expected %h", c, l1_cpu_rdata, ref_mem[(c == 3) ? 0 : 1]);
        end
        if (c == 3) l1_cpu_addr = 32'h4;
        else        l1_cpu_req  = 1'b0;
      end
    end
  endtask

  // Each master raises random requests and holds them until its ready; the
  // model grants at each free slot (lone requester wins, ties alternate) and
  // books the whole transaction's timing from that grant.
  task automatic test_random();
    logic        cpu_act, dev_act, owner_dev, t_valid, t_dev, t_we;
    logic [31:0] t_addr, t_wdata, t_rdata, exp_crd, exp_drd;
    logic [1:0]  eg;
    logic        een, ecr, edr;
    int          t_start, free_at;
    pulse_reset();
    cpu_act = 1'b0; dev_act = 1'b0; owner_dev = 1'b1; t_valid = 1'b0; t_dev = 1'b0; t_we = 1'b0;
    t_addr = '0; t_wdata = '0; t_rdata = '0; exp_crd = '0; exp_drd = '0;
    ecr = 1'b0; edr = 1'b0; t_start = 0; free_at = 0;
    for (int c = 0; c < 600; c++) begin
      if (ecr) cpu_act = 1'b0;
      if (edr) dev_act = 1'b0;
      if (!cpu_act && $urandom_range(0, 2) != 0) begin
        cpu_act = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 31)) << 2; cpu_wdata = $urandom;
      end
      if (!dev_act && $urandom_range(0, 2) != 0) begin
        dev_act = 1'b1; dev_we = 1'($urandom_range(0, 1));
        dev_addr = 32'($urandom_range(0, 31)) << 2; dev_wdata = $urandom;
      end
      cpu_req = cpu_act;
      dev_req = dev_act;
      if (c == free_at) begin
        if (cpu_req || dev_req) begin
          if (cpu_req && dev_req) t_dev = !owner_dev;
          else                    t_dev = dev_req;
          owner_dev = t_dev; t_valid = 1'b1; t_start = c;
          t_we    = t_dev ? dev_we    : cpu_we;
          t_addr  = t_dev ? dev_addr  : cpu_addr;
          t_wdata = t_dev ? dev_wdata : cpu_wdata;
          if (t_we) ref_mem[t_addr[11:2]] = t_wdata;
          else      t_rdata = ref_mem[t_addr[11:2]];
          free_at = c + LAT + 3;
        end else begin
          free_at = c + 1;
        end
      end
      step();
      eg = 2'b00; een = 1'b0; ecr = 1'b0; edr = 1'b0;
      if (t_valid) begin
        eg  = t_dev ? 2'b10 : 2'b01;
        een = (c + 1 == t_start + 1);
        if (c + 1 == t_start + LAT + 2) begin
          ecr = !t_dev; edr = t_dev;
          if (!t_we) begin
            if (t_dev) exp_drd = t_rdata;
            else       exp_crd = t_rdata;
          end
          t_valid = 1'b0;
        end
      end
      vectors++;
      if ({grant, mem_en, cpu_ready, dev_ready} !== {eg, een, ecr, edr}) begin
        miscompares++; $display("FAIL rnd_ctrl c=%0d: got grant=%b en=%b rdy=%b%b expected %b %b %b%b",
                                c + 1, grant, mem_en, cpu_ready, dev_ready, eg, een, ecr, edr);
      end
      vectors++;
      if (cpu_rdata !== exp_crd || dev_rdata !== exp_drd) begin
        miscompares++; $display("FAIL rnd_rdata c=%0d: got %h/%h expected %h/%h", c + 1, cpu_rdata, dev_rdata, exp_crd, exp_drd);
      end
      if (een) begin
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {t_we, t_addr, t_we ? t_wdata : mem_wdata}) begin
          miscompares++; $display("FAIL rnd_mem_fields c=%0d: got we=%b addr=%h wd=%h expected %b %h %h",
                                  c + 1, mem_we, mem_addr, mem_wdata, t_we, t_addr, t_wdata);
        end
      end
    end
    idle_inputs();
    repeat (8) step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_cpu_read();
    test_dev_write();
    test_first_tie();
    test_contention();
    test_reset_mid();
    test_lat1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
